// File: rtl/rob_nway.sv
// Reorder buffer: dispatches, completes and retires up to WIDTH ops per cycle, with squash and flush.
// Latency: an entry can retire at the earliest 2 edges after dispatch (complete at E, retire visible after E).
// Backpressure: an all-or-nothing dispatch group is accepted only when free_slots_o covers it and no squash or flush is active.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-high reset
//   dispatch_en_i/T_i/T_old_i  dispatch lanes (contiguous from lane 0), dispatch_ack_o, dispatch_idx_o
//   free_slots_o             registered ROB_SIZE - count
//   cdb_en_i/cdb_idx_i       completion by ROB index
//   squash_en_i/squash_idx_i keep entries up to and including squash_idx_i
//   flush_i                  discard everything
//   retire_en_o/T_o/T_old_o  in-order retirement, lane 0 oldest
module rob_nway #(
  parameter int ROB_SIZE    = 32,
  parameter int WIDTH       = 2,
  parameter int PREG_NUMBER = 64,
  localparam int TW = $clog2(PREG_NUMBER),
  localparam int IW = $clog2(ROB_SIZE),
  localparam int CW = $clog2(ROB_SIZE + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    dispatch_en_i,
  input  logic [WIDTH*TW-1:0] T_i,
  input  logic [WIDTH*TW-1:0] T_old_i,
  output logic                dispatch_ack_o,
  output logic [WIDTH*IW-1:0] dispatch_idx_o,
  output logic [CW-1:0]       free_slots_o,
  input  logic [WIDTH-1:0]    cdb_en_i,
  input  logic [WIDTH*IW-1:0] cdb_idx_i,
  input  logic                squash_en_i,
  input  logic [IW-1:0]       squash_idx_i,
  input  logic                flush_i,
  output logic [WIDTH-1:0]    retire_en_o,
  output logic [WIDTH*TW-1:0] T_o,
  output logic [WIDTH*TW-1:0] T_old_o
);

  logic [IW-1:0]       r_head;
  logic [IW-1:0]       r_tail;
  logic [CW-1:0]       r_count;
  logic [CW-1:0]       r_free;
  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_done;
  logic [TW-1:0]       r_t    [ROB_SIZE];
  logic [TW-1:0]       r_told [ROB_SIZE];

  logic [CW-1:0]       w_n;
  logic [CW-1:0]       w_r;
  logic                w_ack;
  logic [IW-1:0]       w_dist;
  logic                w_chain;
  logic [WIDTH-1:0]    w_ret;
  logic [ROB_SIZE-1:0] w_kill;
  logic [CW-1:0]       w_count_nxt;

  assign free_slots_o   = r_free;
  assign dispatch_ack_o = w_ack;
  assign retire_en_o    = w_ret;

  // Age of the squashing branch relative to head; entries older than it survive.
  assign w_dist = squash_idx_i - r_head;

  always_comb begin
    w_n = '0;
    for (int k = 0; k < WIDTH; k++) w_n = w_n + CW'(dispatch_en_i[k]);
  end

  assign w_ack = (w_n != '0) && (w_n <= r_free) && !squash_en_i && !flush_i;

  always_comb begin
    dispatch_idx_o = '0;
    for (int k = 0; k < WIDTH; k++) dispatch_idx_o[k*IW +: IW] = r_tail + IW'(k);
  end

  // Retire is an in-order prefix of valid+completed entries. Under squash the
  // prefix is clipped at the branch so nothing being squashed can retire.
  always_comb begin
    w_chain = 1'b1;
    w_ret   = '0;
    w_r     = '0;
    T_o     = '0;
    T_old_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      w_chain = w_chain & r_valid[r_head + IW'(k)] & r_done[r_head + IW'(k)] & !flush_i
                & (!squash_en_i || (IW'(k) <= w_dist));
      w_ret[k] = w_chain;
      if (w_chain) begin
        T_o[k*TW +: TW]     = r_t[r_head + IW'(k)];
        T_old_o[k*TW +: TW] = r_told[r_head + IW'(k)];
        w_r = w_r + CW'(1);
      end
    end
  end

  always_comb begin
    w_kill = '0;
    for (int i = 0; i < ROB_SIZE; i++)
      w_kill[i] = squash_en_i && ((IW'(i) - r_head) > w_dist);
  end

  always_comb begin
    if (flush_i)          w_count_nxt = '0;
    else if (squash_en_i) w_count_nxt = CW'(w_dist) + CW'(1) - w_r;
    else                  w_count_nxt = r_count + (w_ack ? w_n : '0) - w_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_free  <= CW'(ROB_SIZE);
      r_valid <= '0;
      r_done  <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_done  <= '0;
      r_tail  <= r_head;
      r_count <= '0;
      r_free  <= CW'(ROB_SIZE);
    end else begin
      // Order matters: later writes (retire, dispatch, kill) override completion.
      for (int k = 0; k < WIDTH; k++)
        if (cdb_en_i[k] && r_valid[cdb_idx_i[k*IW +: IW]])
          r_done[cdb_idx_i[k*IW +: IW]] <= 1'b1;
      for (int k = 0; k < WIDTH; k++)
        if (w_ret[k]) begin
          r_valid[r_head + IW'(k)] <= 1'b0;
          r_done[r_head + IW'(k)]  <= 1'b0;
        end
      if (w_ack)
        for (int k = 0; k < WIDTH; k++)
          if (dispatch_en_i[k]) begin
            r_valid[r_tail + IW'(k)] <= 1'b1;
            r_done[r_tail + IW'(k)]  <= 1'b0;
            r_t[r_tail + IW'(k)]     <= T_i[k*TW +: TW];
            r_told[r_tail + IW'(k)]  <= T_old_i[k*TW +: TW];
          end
      for (int i = 0; i < ROB_SIZE; i++)
        if (w_kill[i]) begin
          r_valid[i] <= 1'b0;
          r_done[i]  <= 1'b0;
        end
      r_head <= r_head + IW'(w_r);
      if (squash_en_i) r_tail <= squash_idx_i + IW'(1);
      else if (w_ack)  r_tail <= r_tail + IW'(w_n);
      r_count <= w_count_nxt;
      r_free  <= CW'(ROB_SIZE) - w_count_nxt;
    end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway with ROB_SIZE=8, WIDTH=4.
// Each table row drives one cycle, checks the combinational outputs before the edge
// and free_slots_o after it.
module tb_rob_nway;
  localparam int RS = 8;
  localparam int WD = 4;
  localparam int PN = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  dispatch_en_i;
  logic [23:0] T_i, T_old_i;
  logic        dispatch_ack_o;
  logic [11:0] dispatch_idx_o;
  logic [3:0]  free_slots_o;
  logic [3:0]  cdb_en_i;
  logic [11:0] cdb_idx_i;
  logic        squash_en_i;
  logic [2:0]  squash_idx_i;
  logic        flush_i;
  logic [3:0]  retire_en_o;
  logic [23:0] T_o, T_old_o;

  rob_nway #(.ROB_SIZE(RS), .WIDTH(WD), .PREG_NUMBER(PN)) dut (
    .clk(clk), .reset(reset),
    .dispatch_en_i(dispatch_en_i), .T_i(T_i), .T_old_i(T_old_i),
    .dispatch_ack_o(dispatch_ack_o), .dispatch_idx_o(dispatch_idx_o),
    .free_slots_o(free_slots_o),
    .cdb_en_i(cdb_en_i), .cdb_idx_i(cdb_idx_i),
    .squash_en_i(squash_en_i), .squash_idx_i(squash_idx_i),
    .flush_i(flush_i),
    .retire_en_o(retire_en_o), .T_o(T_o), .T_old_o(T_old_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  den;
    logic [23:0] t;
    logic [23:0] told;
    logic [3:0]  cen;
    logic [11:0] cidx;
    logic        sq;
    logic [2:0]  sqi;
    logic        fl;
    logic        e_ack;
    logic [11:0] e_didx;
    logic [3:0]  e_ret;
    logic [23:0] e_t;
    logic [23:0] e_told;
    logic [3:0]  e_free;
  } vec_t;

  vec_t vecs [64];
  int   nv;
  int   checks;
  int   errors;

  function automatic logic [23:0] p6(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  function automatic logic [11:0] p3(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Dispatch indices for tail t: t..t+3 modulo 8.
  function automatic logic [11:0] dx(input int t);
    return p3(t, t + 1, t + 2, t + 3);
  endfunction

  task automatic add(input logic rst, input logic [3:0] den, input logic [23:0] t,
                     input logic [23:0] told, input logic [3:0] cen, input logic [11:0] cidx,
                     input logic sq, input logic [2:0] sqi, input logic fl,
                     input logic ack, input logic [11:0] didx, input logic [3:0] ret,
                     input logic [23:0] et, input logic [23:0] etold, input logic [3:0] free);
    vecs[nv] = '{rst, den, t, told, cen, cidx, sq, sqi, fl, ack, didx, ret, et, etold, free};
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_en_i = '0; T_i = '0; T_old_i = '0;
    cdb_en_i = '0; cdb_idx_i = '0;
    squash_en_i = 1'b0; squash_idx_i = '0; flush_i = 1'b0;
  endtask

  initial begin
    logic [23:0] z6;
    logic [11:0] z3;
    z6 = '0;
    z3 = '0;
    nv = 0;
    checks = 0;
    errors = 0;

    //   rst den     T                    T_old              cen     cidx             sq sqi fl | ack didx    ret     T_o                  T_old_o            free
    // 1: first group of 4
    add(0, 4'b1111, p6(32,33,34,35), p6(1,2,3,4),     4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              4);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              4);
    // 2: out-of-order completion, in-order retire
    add(0, 4'b0000, z6,              z6,              4'b0011, p3(2,3,0,0),   0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              4);
    add(0, 4'b0000, z6,              z6,              4'b0001, p3(0,0,0,0),   0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              4);
    add(0, 4'b0000, z6,              z6,              4'b0001, p3(1,0,0,0),   0, 0, 0,  0, dx(4), 4'b0001, p6(32,0,0,0),     p6(1,0,0,0),     5);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(4), 4'b0111, p6(33,34,35,0),   p6(2,3,4,0),     8);
    // 3: fill from head=4 with wrap, full, no bypass
    add(0, 4'b1111, p6(40,41,42,43), p6(10,11,12,13), 4'b0000, z3,            0, 0, 0,  1, dx(4), 4'b0000, z6,               z6,              4);
    add(0, 4'b1111, p6(44,45,46,47), p6(14,15,16,17), 4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              0);
    add(0, 4'b0001, p6(50,0,0,0),    p6(20,0,0,0),    4'b0000, z3,            0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              0);
    add(0, 4'b0000, z6,              z6,              4'b0011, p3(4,5,0,0),   0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              0);
    add(0, 4'b0011, p6(50,51,0,0),   p6(20,21,0,0),   4'b0000, z3,            0, 0, 0,  0, dx(4), 4'b0011, p6(40,41,0,0),    p6(10,11,0,0),   2);
    add(0, 4'b0011, p6(50,51,0,0),   p6(20,21,0,0),   4'b0000, z3,            0, 0, 0,  1, dx(4), 4'b0000, z6,               z6,              0);
    // reset while full, dispatch requested
    add(1, 4'b1111, p6(1,2,3,4),     p6(1,2,3,4),     4'b0000, z3,            0, 0, 0,  0, dx(6), 4'b0000, z6,               z6,              8);
    // 4: squash idx 2 with same-cycle dispatch and CDB on idx 4
    add(0, 4'b1111, p6(10,11,12,13), p6(20,21,22,23), 4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              4);
    add(0, 4'b0011, p6(14,15,0,0),   p6(24,25,0,0),   4'b0000, z3,            0, 0, 0,  1, dx(4), 4'b0000, z6,               z6,              2);
    add(0, 4'b0011, p6(16,17,0,0),   p6(26,27,0,0),   4'b0001, p3(4,0,0,0),   1, 2, 0,  0, dx(6), 4'b0000, z6,               z6,              5);
    add(0, 4'b0000, z6,              z6,              4'b1111, p3(0,1,2,4),   0, 0, 0,  0, dx(3), 4'b0000, z6,               z6,              5);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(3), 4'b0111, p6(10,11,12,0),   p6(20,21,22,0),  8);
    // 5: move head to 6, entries 6,7,0,1; squash 7 while 6 retires
    add(0, 4'b0111, p6(30,31,32,0),  p6(5,6,7,0),     4'b0000, z3,            0, 0, 0,  1, dx(3), 4'b0000, z6,               z6,              5);
    add(0, 4'b0000, z6,              z6,              4'b0111, p3(3,4,5,0),   0, 0, 0,  0, dx(6), 4'b0000, z6,               z6,              5);
    add(0, 4'b1111, p6(40,41,42,43), p6(8,9,10,11),   4'b0000, z3,            0, 0, 0,  1, dx(6), 4'b0111, p6(30,31,32,0),   p6(5,6,7,0),     4);
    add(0, 4'b0000, z6,              z6,              4'b0001, p3(6,0,0,0),   0, 0, 0,  0, dx(2), 4'b0000, z6,               z6,              4);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            1, 7, 0,  0, dx(2), 4'b0001, p6(40,0,0,0),     p6(8,0,0,0),     7);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(0), 4'b0000, z6,               z6,              7);
    // 6: flush with 5 entries, head completed
    add(0, 4'b1111, p6(50,51,52,53), p6(12,13,14,15), 4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              3);
    add(0, 4'b0000, z6,              z6,              4'b0001, p3(7,0,0,0),   0, 0, 0,  0, dx(4), 4'b0000, z6,               z6,              3);
    add(0, 4'b0001, p6(55,0,0,0),    p6(9,0,0,0),     4'b0001, p3(0,0,0,0),   0, 0, 1,  0, dx(4), 4'b0000, z6,               z6,              8);
    add(0, 4'b0001, p6(60,0,0,0),    p6(16,0,0,0),    4'b0000, z3,            0, 0, 0,  1, dx(7), 4'b0000, z6,               z6,              7);
    add(0, 4'b0000, z6,              z6,              4'b0001, p3(7,0,0,0),   0, 0, 0,  0, dx(0), 4'b0000, z6,               z6,              7);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(0), 4'b0001, p6(60,0,0,0),     p6(16,0,0,0),    8);
    // reset mid-fill
    add(0, 4'b0011, p6(1,2,0,0),     p6(3,4,0,0),     4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              6);
    add(1, 4'b0011, p6(5,6,0,0),     p6(7,8,0,0),     4'b0000, z3,            0, 0, 0,  1, dx(2), 4'b0000, z6,               z6,              8);
    add(0, 4'b0000, z6,              z6,              4'b0000, z3,            0, 0, 0,  0, dx(0), 4'b0000, z6,               z6,              8);
    // group larger than free space is rejected whole
    add(0, 4'b1111, p6(1,2,3,4),     z6,              4'b0000, z3,            0, 0, 0,  1, dx(0), 4'b0000, z6,               z6,              4);
    add(0, 4'b0011, p6(5,6,0,0),     z6,              4'b0000, z3,            0, 0, 0,  1, dx(4), 4'b0000, z6,               z6,              2);
    add(0, 4'b0111, p6(7,8,9,0),     z6,              4'b0000, z3,            0, 0, 0,  0, dx(6), 4'b0000, z6,               z6,              2);
    add(0, 4'b0011, p6(7,8,0,0),     z6,              4'b0000, z3,            0, 0, 0,  1, dx(6), 4'b0000, z6,               z6,              0);

    // Reset state check.
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset free_slots", 32'(free_slots_o), 32'd8);
    chk("reset retire_en", 32'(retire_en_o), 32'd0);
    chk("reset ack", 32'(dispatch_ack_o), 32'd0);
    chk("reset dispatch_idx", 32'(dispatch_idx_o), 32'(dx(0)));

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      dispatch_en_i = vecs[i].den;
      T_i           = vecs[i].t;
      T_old_i       = vecs[i].told;
      cdb_en_i      = vecs[i].cen;
      cdb_idx_i     = vecs[i].cidx;
      squash_en_i   = vecs[i].sq;
      squash_idx_i  = vecs[i].sqi;
      flush_i       = vecs[i].fl;
      #1;
      chk($sformatf("v%0d ack", i), 32'(dispatch_ack_o), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d dispatch_idx", i), 32'(dispatch_idx_o), 32'(vecs[i].e_didx));
      chk($sformatf("v%0d retire_en", i), 32'(retire_en_o), 32'(vecs[i].e_ret));
      chk($sformatf("v%0d T_o", i), 32'(T_o), 32'(vecs[i].e_t));
      chk($sformatf("v%0d T_old_o", i), 32'(T_old_o), 32'(vecs[i].e_told));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d free_slots", i), 32'(free_slots_o), 32'(vecs[i].e_free));
    end

    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
